// File: rtl/button_pkg.sv
// Shared constants and helpers for the push-button input path.
package button_pkg;

    localparam int unsigned CLOCK_HZ    = 100_000_000;
    localparam int unsigned DEBOUNCE_MS = 10;
    localparam int unsigned HOLD_MS     = 1000;

    // Default cycle counts derived from the board clock.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLOCK_HZ / 1000) * DEBOUNCE_MS;
    localparam int unsigned HOLD_CYCLES_DEFAULT     = (CLOCK_HZ / 1000) * HOLD_MS;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: two-flop synchronizer, debounce counter and long-hold detector.
module button_channel
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset_,
    input  logic btn,
    output logic level,
    output logic pressed,
    output logic released,
    output logic held
);

    localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
    // One extra bit so the hold counter can hold HOLD_CYCLES itself.
    localparam int unsigned HW = cnt_width(HOLD_CYCLES) + 1;

    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HCNT_PRE  = HW'(HOLD_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          pressed_q, pressed_d;
    logic          released_q, released_d;
    logic          held_q, held_d;

    // Accept a new synchronized value only after it persists DEBOUNCE_CYCLES cycles.
    always_comb begin
        level_d    = level_q;
        dcnt_d     = '0;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        if (sync2_q != level_q) begin
            if (dcnt_q == DCNT_LAST) begin
                level_d    = sync2_q;
                pressed_d  = sync2_q;
                released_d = ~sync2_q;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
    end

    // Count time spent high; saturation makes held fire once per press.
    always_comb begin
        hcnt_d = hcnt_q;
        held_d = 1'b0;
        if (!level_q) begin
            hcnt_d = '0;
        end else if (hcnt_q != HCNT_MAX) begin
            hcnt_d = hcnt_q + HW'(1);
            held_d = (hcnt_q == HCNT_PRE);
        end
    end

    // Synchronizer, counters and registered outputs.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            level_q    <= 1'b0;
            dcnt_q     <= '0;
            hcnt_q     <= '0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            sync1_q    <= btn;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            dcnt_q     <= dcnt_d;
            hcnt_q     <= hcnt_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            held_q     <= held_d;
        end
    end

    assign level    = level_q;
    assign pressed  = pressed_q;
    assign released = released_q;
    assign held     = held_q;

endmodule

// File: rtl/button_events.sv
// Board push-button conditioning: WIDTH independent debounced channels with event pulses.
module button_events
    import button_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic [WIDTH-1:0] btn,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] released,
    output logic [WIDTH-1:0] held
);

    // One self-contained channel per button pin.
    for (genvar i = 0; i < WIDTH; i++) begin : gen_chan
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES)
        ) u_chan (
            .clock   (clock),
            .reset_  (reset_),
            .btn     (btn[i]),
            .level   (level[i]),
            .pressed (pressed[i]),
            .released(released[i]),
            .held    (held[i])
        );
    end

endmodule

// File: tb/tb_button_events.sv
// Self-checking bench for button_events: event scoreboard plus table-driven pulse lengths.
module tb_button_events;

    localparam int D = 4;
    localparam int H = 16;
    localparam int KP = 0;  // pressed
    localparam int KR = 1;  // released
    localparam int KH = 2;  // held

    logic       clock = 1'b0;
    logic       reset_;
    logic [3:0] btn;
    logic [3:0] level, pressed, released, held;

    button_events #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H)
    ) dut (
        .clock   (clock),
        .reset_  (reset_),
        .btn     (btn),
        .level   (level),
        .pressed (pressed),
        .released(released),
        .held    (held)
    );

    always #5 clock = ~clock;

    typedef struct {
        int edge_no;
        int ch;
        int kind;
    } ev_t;

    typedef struct {
        int ch;
        int len;
        bit exp_press;
        bit exp_held;
    } vec_t;

    ev_t  exp_q[$];
    ev_t  got_e;
    vec_t vecs[8];
    int   edge_n   = 0;
    int   checks   = 0;
    int   failures = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int e, input int ch, input int kind);
        ev_t x;
        x.edge_no = e;
        x.ch      = ch;
        x.kind    = kind;
        exp_q.push_back(x);
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at edge %0d", name, got, exp, edge_n);
        end
    endtask

    // Count edges and match every observed pulse against the expected-event queue.
    always begin
        @(posedge clock);
        edge_n++;
        #1;
        for (int c = 0; c < 4; c++) begin
            for (int t = 0; t < 3; t++) begin
                if ((t == KP && pressed[c]) || (t == KR && released[c]) || (t == KH && held[c]))
                begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL event: unexpected ch=%0d kind=%0d at edge %0d, none expected",
                                 c, t, edge_n);
                    end else begin
                        got_e = exp_q.pop_front();
                        if (got_e.edge_no != edge_n || got_e.ch != c || got_e.kind != t) begin
                            failures++;
                            $display("FAIL event: got ch=%0d kind=%0d edge=%0d, expected ch=%0d kind=%0d edge=%0d",
                                     c, t, edge_n, got_e.ch, got_e.kind, got_e.edge_no);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        int         s;
        logic [3:0] lv;

        // ch, high length, expect press, expect held
        vecs[0] = '{0, 20, 1'b1, 1'b1};  // clean press, long enough to hold
        vecs[1] = '{2, 3,  1'b0, 1'b0};  // glitch shorter than debounce
        vecs[2] = '{2, 5,  1'b1, 1'b0};  // just-long-enough pulse
        vecs[3] = '{3, 40, 1'b1, 1'b1};  // long hold, single held
        vecs[4] = '{1, 10, 1'b1, 1'b0};  // short press
        vecs[5] = '{0, 4,  1'b1, 1'b0};  // exactly DEBOUNCE_CYCLES
        vecs[6] = '{1, 15, 1'b1, 1'b0};  // one short of hold
        vecs[7] = '{3, 17, 1'b1, 1'b1};  // one past hold

        reset_ = 1'b0;
        btn    = '0;
        repeat (3) tick();
        check("reset_state", {level, pressed, released, held}, 16'h0);
        reset_ = 1'b1;
        repeat (3) tick();
        check("idle_after_reset", {level, pressed, released, held}, 16'h0);

        for (int v = 0; v < 8; v++) begin
            k = edge_n + 1;
            if (vecs[v].exp_press) begin
                push(k + 1 + D, vecs[v].ch, KP);
                if (vecs[v].exp_held) push(k + 1 + D + H, vecs[v].ch, KH);
                push(k + vecs[v].len + 1 + D, vecs[v].ch, KR);
            end
            lv = '0;
            if (vecs[v].exp_press) lv[vecs[v].ch] = 1'b1;
            for (int i = 0; i < vecs[v].len + 40; i++) begin
                btn[vecs[v].ch] = (i < vecs[v].len);
                tick();
                if (i == D + 1) check("vec_level", {12'h0, level}, {12'h0, lv});
            end
        end

        // Bounce on ch1: 1,0,1,0 then stable high for 12 samples.
        s = edge_n + 1;
        push(s + 4 + 1 + D, 1, KP);
        push(s + 16 + 1 + D, 1, KR);
        for (int i = 0; i < 56; i++) begin
            btn[1] = (i < 4) ? (i % 2 == 0) : (i < 16);
            tick();
            if (i == 8) check("bounce_level_before", {12'h0, level}, 16'h0);
        end

        // Reset while ch0 is high and ch1 is mid-debounce.
        btn = '0;
        btn[0] = 1'b1;
        k = edge_n + 1;
        push(k + 1 + D, 0, KP);
        repeat (7) tick();
        check("rst_pre_level", {12'h0, level}, 16'h1);
        btn[1] = 1'b1;
        repeat (3) tick();
        reset_ = 1'b0;
        #1;
        check("rst_async_clear", {level, pressed, released, held}, 16'h0);
        btn[1] = 1'b0;
        repeat (3) tick();
        check("rst_held_low", {level, pressed, released, held}, 16'h0);
        reset_ = 1'b1;
        k = edge_n + 1;
        push(k + 1 + D, 0, KP);
        repeat (5) tick();
        check("rst_before_repress", {12'h0, level}, 16'h0);
        repeat (4) tick();
        btn[0] = 1'b0;
        push(k + 9 + 1 + D, 0, KR);
        repeat (30) tick();
        check("final_idle", {level, pressed, released, held}, 16'h0);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events: got %0d left in queue, expected 0 (next edge=%0d ch=%0d kind=%0d)",
                     exp_q.size(), exp_q[0].edge_no, exp_q[0].ch, exp_q[0].kind);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
